// File: rtl/emu_clk_ctrl.sv
// Emulator clock controller: pause/run/step sequencing of the DUT clock enable,
// per-domain clock dividers, tick counter and scan-chain clock gating.
module emu_clk_ctrl #(
  parameter int NUM_CLK    = 2,
  parameter int NUM_STALL  = 2,
  parameter int CNT_WIDTH  = 64,
  parameter int STEP_WIDTH = 32,
  parameter int DIV_WIDTH  = 4
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         pause_req,
  input  logic                         step_valid,
  output logic                         step_ready,
  input  logic [STEP_WIDTH-1:0]        step_count,
  output logic                         step_done,
  input  logic [NUM_STALL-1:0]         stall_in,
  input  logic [NUM_CLK*DIV_WIDTH-1:0] div,
  input  logic                         ff_scan,
  input  logic                         ram_scan,
  input  logic                         cnt_clr,
  output logic                         tick,
  output logic [NUM_CLK-1:0]           clk_en,
  output logic                         ff_clk_en,
  output logic                         ram_clk_en,
  output logic                         running,
  output logic [CNT_WIDTH-1:0]         cycle_cnt,
  output logic                         scan_err
);

  typedef enum logic [1:0] {
    PAUSED = 2'd0,
    RUN    = 2'd1,
    STEP   = 2'd2
  } state_t;

  state_t                r_state;
  logic [STEP_WIDTH-1:0] r_remain;
  logic                  r_step_done;
  logic [CNT_WIDTH-1:0]  r_cycle_cnt;
  logic                  r_scan_err;

  logic w_stall_any;
  logic w_tick;
  logic w_step_ready;
  logic w_step_accept;
  logic w_scan_any;

  assign w_stall_any = |stall_in;
  assign w_scan_any  = ff_scan | ram_scan;

  // Pause acts in the same cycle it is raised, so RUN never emits a trailing tick.
  always_comb begin
    w_tick = 1'b0;
    unique case (r_state)
      RUN:     w_tick = !pause_req && !w_stall_any;
      STEP:    w_tick = !w_stall_any;
      default: w_tick = 1'b0;
    endcase
  end

  // resetn gates ready directly so no handshake can be seen while reset is held.
  assign w_step_ready  = resetn && (r_state == PAUSED) && pause_req;
  assign w_step_accept = step_valid && w_step_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= PAUSED;
      r_remain    <= '0;
      r_step_done <= 1'b0;
    end else begin
      r_step_done <= 1'b0;
      unique case (r_state)
        PAUSED: begin
          if (w_step_accept) begin
            if (step_count == '0) begin
              r_step_done <= 1'b1;
            end else begin
              r_state  <= STEP;
              r_remain <= step_count;
            end
          end else if (!pause_req) begin
            r_state <= RUN;
          end
        end
        RUN: begin
          if (pause_req) begin
            r_state <= PAUSED;
          end
        end
        STEP: begin
          if (w_tick) begin
            if (r_remain == STEP_WIDTH'(1)) begin
              r_state     <= PAUSED;
              r_remain    <= '0;
              r_step_done <= 1'b1;
            end else begin
              r_remain <= r_remain - STEP_WIDTH'(1);
            end
          end
        end
        default: begin
          r_state <= PAUSED;
        end
      endcase
    end
  end

  // Clear has priority over a coincident tick.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cycle_cnt <= '0;
    end else if (cnt_clr) begin
      r_cycle_cnt <= '0;
    end else if (w_tick) begin
      r_cycle_cnt <= r_cycle_cnt + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_scan_err <= 1'b0;
    end else if (w_scan_any && (r_state != PAUSED)) begin
      r_scan_err <= 1'b1;
    end
  end

  // The >= compare lets a divider lowered below its running count fire on the next tick.
  generate
    for (genvar gi = 0; gi < NUM_CLK; gi++) begin : g_dom
      logic [DIV_WIDTH-1:0] r_div_cnt;
      logic [DIV_WIDTH-1:0] w_div;
      logic                 w_fire;

      assign w_div       = div[gi*DIV_WIDTH +: DIV_WIDTH];
      assign w_fire      = (r_div_cnt >= w_div);
      assign clk_en[gi]  = w_tick && w_fire;

      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          r_div_cnt <= '0;
        end else if (w_tick) begin
          if (w_fire) begin
            r_div_cnt <= '0;
          end else begin
            r_div_cnt <= r_div_cnt + DIV_WIDTH'(1);
          end
        end
      end
    end
  endgenerate

  assign tick       = w_tick;
  assign step_ready = w_step_ready;
  assign step_done  = r_step_done;
  assign ff_clk_en  = w_tick || ff_scan;
  assign ram_clk_en = w_tick || ram_scan;
  assign running    = (r_state != PAUSED);
  assign cycle_cnt  = r_cycle_cnt;
  assign scan_err   = r_scan_err;

endmodule

// File: tb/tb_emu_clk_ctrl.sv
// Directed bench for emu_clk_ctrl: a cycle-level reference model compared on every
// falling edge, plus hand-computed checkpoints for each scenario.
module tb_emu_clk_ctrl;
  localparam int NUM_CLK    = 2;
  localparam int NUM_STALL  = 2;
  localparam int CNT_WIDTH  = 8;
  localparam int STEP_WIDTH = 16;
  localparam int DIV_WIDTH  = 4;

  logic                         clk = 1'b0;
  logic                         resetn;
  logic                         pause_req;
  logic                         step_valid;
  logic                         step_ready;
  logic [STEP_WIDTH-1:0]        step_count;
  logic                         step_done;
  logic [NUM_STALL-1:0]         stall_in;
  logic [NUM_CLK*DIV_WIDTH-1:0] div;
  logic                         ff_scan;
  logic                         ram_scan;
  logic                         cnt_clr;
  logic                         tick;
  logic [NUM_CLK-1:0]           clk_en;
  logic                         ff_clk_en;
  logic                         ram_clk_en;
  logic                         running;
  logic [CNT_WIDTH-1:0]         cycle_cnt;
  logic                         scan_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Running totals of DUT activity observed on falling edges.
  int tick_seen = 0;
  int done_seen = 0;
  int en_seen [NUM_CLK];

  emu_clk_ctrl #(
    .NUM_CLK   (NUM_CLK),
    .NUM_STALL (NUM_STALL),
    .CNT_WIDTH (CNT_WIDTH),
    .STEP_WIDTH(STEP_WIDTH),
    .DIV_WIDTH (DIV_WIDTH)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .pause_req (pause_req),
    .step_valid(step_valid),
    .step_ready(step_ready),
    .step_count(step_count),
    .step_done (step_done),
    .stall_in  (stall_in),
    .div       (div),
    .ff_scan   (ff_scan),
    .ram_scan  (ram_scan),
    .cnt_clr   (cnt_clr),
    .tick      (tick),
    .clk_en    (clk_en),
    .ff_clk_en (ff_clk_en),
    .ram_clk_en(ram_clk_en),
    .running   (running),
    .cycle_cnt (cycle_cnt),
    .scan_err  (scan_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode 0 = paused, 1 = free running, 2 = stepping.
  int          m_mode = 0;
  int          m_left = 0;
  int unsigned m_ticks = 0;
  bit          m_done = 0;
  bit          m_err = 0;
  int          m_since [NUM_CLK];

  initial begin
    for (int i = 0; i < NUM_CLK; i++) begin
      m_since[i] = 0;
      en_seen[i] = 0;
    end
  end

  always @(negedge clk) begin : model
    bit                 stall, e_tick, e_ready;
    logic [NUM_CLK-1:0] e_en;
    int                 dv, n_mode, n_left;
    bit                 n_done;

    if (!resetn) begin
      m_mode  = 0;
      m_left  = 0;
      m_ticks = 0;
      m_done  = 0;
      m_err   = 0;
      for (int i = 0; i < NUM_CLK; i++) m_since[i] = 0;
    end

    stall   = (stall_in != '0);
    e_tick  = (m_mode == 1) ? (!pause_req && !stall) : (m_mode == 2) ? !stall : 1'b0;
    e_ready = resetn && (m_mode == 0) && pause_req;
    e_en    = '0;
    for (int i = 0; i < NUM_CLK; i++) begin
      dv = int'(div[i*DIV_WIDTH +: DIV_WIDTH]);
      e_en[i] = e_tick && (m_since[i] >= dv);
    end

    chk("tick",       64'(tick),       64'(e_tick));
    chk("clk_en",     64'(clk_en),     64'(e_en));
    chk("ff_clk_en",  64'(ff_clk_en),  64'(e_tick || ff_scan));
    chk("ram_clk_en", 64'(ram_clk_en), 64'(e_tick || ram_scan));
    chk("step_ready", 64'(step_ready), 64'(e_ready));
    chk("step_done",  64'(step_done),  64'(m_done));
    chk("running",    64'(running),    64'(m_mode != 0));
    chk("cycle_cnt",  64'(cycle_cnt),  64'(m_ticks % 256));
    chk("scan_err",   64'(scan_err),   64'(m_err));

    tick_seen += int'(tick);
    done_seen += int'(step_done);
    for (int i = 0; i < NUM_CLK; i++) en_seen[i] += int'(clk_en[i]);

    if (resetn) begin
      n_mode = m_mode;
      n_left = m_left;
      n_done = 1'b0;
      if (m_mode == 0) begin
        if (step_valid && e_ready) begin
          if (step_count == 0) n_done = 1'b1;
          else begin
            n_mode = 2;
            n_left = int'(step_count);
          end
        end else if (!pause_req) n_mode = 1;
      end else if (m_mode == 1) begin
        if (pause_req) n_mode = 0;
      end else if (e_tick) begin
        n_left = m_left - 1;
        if (n_left == 0) begin
          n_mode = 0;
          n_done = 1'b1;
        end
      end
      if ((ff_scan || ram_scan) && m_mode != 0) m_err = 1'b1;
      if (cnt_clr) m_ticks = 0;
      else if (e_tick) m_ticks = m_ticks + 1;
      for (int i = 0; i < NUM_CLK; i++) begin
        if (e_tick) m_since[i] = e_en[i] ? 0 : m_since[i] + 1;
      end
      m_mode = n_mode;
      m_left = n_left;
      m_done = n_done;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Issue a step request (pause_req must already be high) and wait, bounded, for completion.
  task automatic do_step(input int n);
    bit got;
    step_count = STEP_WIDTH'(n);
    step_valid = 1'b1;
    cyc(1);
    step_valid = 1'b0;
    got = 1'b0;
    for (int k = 0; k < n + 50 && !got; k++) begin
      if (step_done) got = 1'b1;
      else cyc(1);
    end
    chk("step_completes", 64'(got), 64'd1);
    $display("step of %0d ticks finished, cycle_cnt=%0d", n, cycle_cnt);
  endtask

  initial begin : stim
    int t0, d0, e0, e1;
    resetn     = 1'b1;
    pause_req  = 1'b1;
    step_valid = 1'b0;
    step_count = '0;
    stall_in   = '0;
    div        = '0;
    ff_scan    = 1'b1;
    ram_scan   = 1'b0;
    cnt_clr    = 1'b0;
    #1 resetn = 1'b0;
    cyc(3);
    chk("rst_tick",       64'(tick),       64'd0);
    chk("rst_clk_en",     64'(clk_en),     64'd0);
    chk("rst_step_ready", 64'(step_ready), 64'd0);
    chk("rst_ff_clk_en",  64'(ff_clk_en),  64'd1);
    chk("rst_cycle_cnt",  64'(cycle_cnt),  64'd0);
    $display("reset held: tick=%0d step_ready=%0d ff_clk_en=%0d", tick, step_ready, ff_clk_en);
    ff_scan = 1'b0;
    resetn  = 1'b1;
    cyc(1);
    chk("paused_ready", 64'(step_ready), 64'd1);

    // Free run for 10 ticks, then pause takes effect in the same cycle.
    t0 = tick_seen;
    pause_req = 1'b0;
    cyc(11);
    pause_req = 1'b1;
    #1;
    chk("pause_same_cycle", 64'(tick), 64'd0);
    cyc(1);
    chk("run10_ticks", 64'(tick_seen - t0), 64'd10);
    chk("run10_cnt",   64'(cycle_cnt),      64'd10);
    $display("run 10 then pause: cycle_cnt=%0d running=%0d", cycle_cnt, running);

    // Step of 5 with a two-cycle stall in the middle.
    t0 = tick_seen;
    d0 = done_seen;
    step_count = 16'd5;
    step_valid = 1'b1;
    cyc(1);
    step_valid = 1'b0;
    cyc(2);
    stall_in = 2'b01;
    #1;
    chk("stall_no_tick", 64'(tick), 64'd0);
    cyc(2);
    stall_in = 2'b00;
    cyc(3);
    chk("step5_done",    64'(step_done),      64'd1);
    chk("step5_ticks",   64'(tick_seen - t0), 64'd5);
    chk("step5_cnt",     64'(cycle_cnt),      64'd15);
    chk("step5_paused",  64'(running),        64'd0);
    cyc(1);
    chk("step5_one_pulse", 64'(done_seen - d0), 64'd1);
    $display("step 5 with stall: ticks=%0d cycle_cnt=%0d", tick_seen - t0, cycle_cnt);

    // Zero-length step is accepted and completes immediately.
    do_step(0);
    chk("step0_cnt", 64'(cycle_cnt), 64'd15);

    // Domain 0 divides by 3, domain 1 follows tick.
    div = {4'd0, 4'd2};
    e0 = en_seen[0];
    e1 = en_seen[1];
    do_step(12);
    chk("div2_pulses", 64'(en_seen[0] - e0), 64'd4);
    chk("div0_pulses", 64'(en_seen[1] - e1), 64'd12);
    chk("div_cnt",     64'(cycle_cnt),       64'd27);

    // Lowering the ratio below the running count fires on the next tick.
    div = {4'd0, 4'd5};
    e0 = en_seen[0];
    do_step(3);
    chk("div5_no_pulse", 64'(en_seen[0] - e0), 64'd0);
    div = {4'd0, 4'd1};
    do_step(1);
    chk("div_lowered_fires", 64'(en_seen[0] - e0), 64'd1);

    // Counter wrap and clear priority.
    cnt_clr = 1'b1;
    cyc(1);
    cnt_clr = 1'b0;
    chk("clr_paused", 64'(cycle_cnt), 64'd0);
    do_step(255);
    chk("cnt_255", 64'(cycle_cnt), 64'd255);
    do_step(1);
    chk("cnt_wrap", 64'(cycle_cnt), 64'd0);
    cnt_clr = 1'b1;
    do_step(3);
    cnt_clr = 1'b0;
    chk("clr_beats_tick", 64'(cycle_cnt), 64'd0);

    // Scan enables: legal while paused, flagged while running.
    ff_scan = 1'b1;
    #1;
    chk("scan_ff_en",   64'(ff_clk_en), 64'd1);
    chk("scan_no_tick", 64'(tick),      64'd0);
    cyc(1);
    chk("scan_paused_ok", 64'(scan_err), 64'd0);
    ff_scan   = 1'b0;
    pause_req = 1'b0;
    cyc(1);
    chk("scan_running", 64'(running), 64'd1);
    ram_scan = 1'b1;
    #1;
    chk("scan_ram_en", 64'(ram_clk_en), 64'd1);
    cyc(1);
    ram_scan  = 1'b0;
    pause_req = 1'b1;
    chk("scan_err_set", 64'(scan_err), 64'd1);
    cyc(3);
    chk("scan_err_sticky", 64'(scan_err), 64'd1);
    $display("scan while running: scan_err=%0d", scan_err);

    // Reset in the middle of a step leaves remain=3 unfinished.
    step_count = 16'd10;
    step_valid = 1'b1;
    cyc(1);
    step_valid = 1'b0;
    cyc(7);
    d0 = done_seen;
    resetn = 1'b0;
    #1;
    chk("mid_rst_running", 64'(running),    64'd0);
    chk("mid_rst_cnt",     64'(cycle_cnt),  64'd0);
    chk("mid_rst_clk_en",  64'(clk_en),     64'd0);
    chk("mid_rst_ready",   64'(step_ready), 64'd0);
    chk("mid_rst_err",     64'(scan_err),   64'd0);
    cyc(2);
    resetn = 1'b1;
    cyc(3);
    chk("mid_rst_no_done", 64'(done_seen - d0), 64'd0);
    $display("reset mid-step: running=%0d cycle_cnt=%0d", running, cycle_cnt);

    // First edge with pause_req low after reset enters RUN.
    pause_req = 1'b0;
    cyc(1);
    chk("post_rst_run", 64'(running), 64'd1);
    cyc(4);
    chk("post_rst_cnt", 64'(cycle_cnt), 64'd4);
    pause_req = 1'b1;
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
